// File: rtl/sim_exit_responder.sv
// Wishbone slave that lets software running on the simulated CPU end the run.
// A write to EXIT latches a pass/fail code. A heartbeat watchdog substitutes a
// fixed failure code if software stops writing HEARTBEAT. After a drain period
// (so trace/UART output can flush) the sticky sim_done/sim_pass outputs tell
// the testbench top how to finish.
module sim_exit_responder #(
    parameter int unsigned DRAIN_CYCLES       = 16,
    parameter int unsigned HEARTBEAT_LIMIT    = 1000000,
    parameter logic [31:0] WATCHDOG_EXIT_CODE = 32'hFFFF_FFFF
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    input  logic        wb_we_i,
    input  logic [3:0]  wb_adr_i,
    input  logic [3:0]  wb_sel_i,
    input  logic [31:0] wb_dat_i,
    output logic [31:0] wb_dat_o,
    output logic        wb_ack_o,
    output logic        wb_err_o,
    output logic        sim_done,
    output logic        sim_pass,
    output logic [31:0] exit_code
);

    localparam logic [1:0]  REG_EXIT      = 2'd0;
    localparam logic [1:0]  REG_HEARTBEAT = 2'd1;
    localparam logic [1:0]  REG_TICKS     = 2'd2;
    localparam logic [1:0]  REG_STATUS    = 2'd3;
    localparam logic [31:0] DRAIN_LOAD    = 32'(DRAIN_CYCLES) - 32'd1;
    localparam logic [31:0] HB_LAST       = 32'(HEARTBEAT_LIMIT) - 32'd1;
    localparam logic        HB_EN         = (HEARTBEAT_LIMIT != 32'd0);
    localparam logic [31:0] ALL_ONES      = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRAIN = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t      state_r;
    logic [31:0] drain_cnt_r;
    logic [31:0] tick_count_r;
    logic [31:0] idle_count_r;

    logic        req_s;
    logic        wr_ok_s;
    logic        wr_bad_s;
    logic        exit_wr_s;
    logic        hb_wr_s;
    logic        wd_fire_s;
    logic        draining_s;
    logic [31:0] rd_data_s;
    logic        unused_adr_s;

    // Byte lanes [1:0] of the address never select anything.
    assign unused_adr_s = ^wb_adr_i[1:0];

    // A new request is only taken while no response is being presented, so
    // back-to-back strobes are served every other cycle.
    assign req_s      = wb_cyc_i & wb_stb_i & ~wb_ack_o & ~wb_err_o;
    assign wr_ok_s    = req_s & wb_we_i & (wb_sel_i == 4'hF);
    assign wr_bad_s   = req_s & wb_we_i & (wb_sel_i != 4'hF);
    assign exit_wr_s  = wr_ok_s & (wb_adr_i[3:2] == REG_EXIT);
    assign hb_wr_s    = wr_ok_s & (wb_adr_i[3:2] == REG_HEARTBEAT);
    // A heartbeat landing on the expiry cycle rescues the run.
    assign wd_fire_s  = HB_EN & (state_r == ST_IDLE) & (idle_count_r == HB_LAST) & ~hb_wr_s;
    assign draining_s = (state_r == ST_DRAIN);

    // Read data selection from the register map.
    always_comb begin
        rd_data_s = 32'd0;
        case (wb_adr_i[3:2])
            REG_EXIT:      rd_data_s = exit_code;
            REG_HEARTBEAT: rd_data_s = idle_count_r;
            REG_TICKS:     rd_data_s = tick_count_r;
            REG_STATUS:    rd_data_s = {29'd0, draining_s, sim_pass, sim_done};
            default:       rd_data_s = 32'd0;
        endcase
    end

    // Bus response: single-cycle ack/err pulse with read data valid alongside ack.
    always_ff @(posedge clock) begin
        if (reset) begin
            wb_ack_o <= 1'b0;
            wb_err_o <= 1'b0;
            wb_dat_o <= 32'd0;
        end else begin
            wb_ack_o <= req_s & ~wr_bad_s;
            wb_err_o <= wr_bad_s;
            wb_dat_o <= (req_s & ~wb_we_i) ? rd_data_s : 32'd0;
        end
    end

    // End-of-run state machine; the first accepted exit request owns exit_code.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            drain_cnt_r <= 32'd0;
            exit_code   <= 32'd0;
            sim_done    <= 1'b0;
            sim_pass    <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (exit_wr_s) begin
                        exit_code   <= wb_dat_i;
                        drain_cnt_r <= DRAIN_LOAD;
                        state_r     <= ST_DRAIN;
                    end else if (wd_fire_s) begin
                        exit_code   <= WATCHDOG_EXIT_CODE;
                        drain_cnt_r <= DRAIN_LOAD;
                        state_r     <= ST_DRAIN;
                    end else begin
                        state_r     <= ST_IDLE;
                    end
                end
                ST_DRAIN: begin
                    if (drain_cnt_r == 32'd0) begin
                        state_r     <= ST_DONE;
                    end else begin
                        drain_cnt_r <= drain_cnt_r - 32'd1;
                    end
                end
                ST_DONE: begin
                    state_r <= ST_DONE;
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
            sim_done <= (state_r == ST_DONE);
            sim_pass <= (state_r == ST_DONE) && (exit_code == 32'd0);
        end
    end

    // Free-running tick counter and heartbeat idle counter, both saturating.
    always_ff @(posedge clock) begin
        if (reset) begin
            tick_count_r <= 32'd0;
            idle_count_r <= 32'd0;
        end else begin
            if ((state_r != ST_DONE) && (tick_count_r != ALL_ONES)) begin
                tick_count_r <= tick_count_r + 32'd1;
            end
            if (state_r == ST_IDLE) begin
                if (hb_wr_s) begin
                    idle_count_r <= 32'd0;
                end else if (idle_count_r != ALL_ONES) begin
                    idle_count_r <= idle_count_r + 32'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_sim_exit_responder.sv
// Randomised scoreboard bench for sim_exit_responder. The reference model is
// event-based: it remembers the edge of the last reset, the last heartbeat and
// the accepted exit request, and derives every register value from them.
module tb_sim_exit_responder;

    localparam int          D  = 4;
    localparam int          L  = 100;
    localparam logic [31:0] WD = 32'hFFFF_FFFF;

    logic        clock    = 1'b0;
    logic        reset    = 1'b1;
    logic        wb_cyc_i = 1'b0;
    logic        wb_stb_i = 1'b0;
    logic        wb_we_i  = 1'b0;
    logic [3:0]  wb_adr_i = 4'd0;
    logic [3:0]  wb_sel_i = 4'd0;
    logic [31:0] wb_dat_i = 32'd0;
    logic [31:0] wb_dat_o;
    logic        wb_ack_o;
    logic        wb_err_o;
    logic        sim_done;
    logic        sim_pass;
    logic [31:0] exit_code;

    sim_exit_responder #(
        .DRAIN_CYCLES(D),
        .HEARTBEAT_LIMIT(L),
        .WATCHDOG_EXIT_CODE(WD)
    ) dut (
        .clock(clock), .reset(reset),
        .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i), .wb_we_i(wb_we_i),
        .wb_adr_i(wb_adr_i), .wb_sel_i(wb_sel_i), .wb_dat_i(wb_dat_i),
        .wb_dat_o(wb_dat_o), .wb_ack_o(wb_ack_o), .wb_err_o(wb_err_o),
        .sim_done(sim_done), .sim_pass(sim_pass), .exit_code(exit_code)
    );

    always #5 clock = ~clock;

    typedef struct {
        bit          err;
        logic [31:0] dat;
    } resp_t;

    resp_t       sb_q[$];
    int          checks = 0;
    int          errors = 0;
    int          ecount = 0;
    bit          armed  = 1'b0;
    int          rst_e  = 0;
    int          hb_e   = 0;
    int          end_e  = -1;
    int          last_req_e = -10;
    logic [31:0] end_code = 32'd0;
    logic [31:0] last_rdata = 32'd0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
        end
    endtask

    // Register contents as seen by a request sampled at edge e.
    function automatic logic [31:0] model_read(input logic [1:0] r, input int e);
        bit ended;
        int last;
        bit drn, dn, ps;
        ended = (end_e >= 0);
        case (r)
            2'd0: return ended ? end_code : 32'd0;
            2'd1: return ended ? 32'(end_e - hb_e) : 32'(e - 1 - hb_e);
            2'd2: begin
                last = (ended && (end_e + D < e - 1)) ? end_e + D : e - 1;
                return 32'(last - rst_e);
            end
            default: begin
                drn = ended && (e - 1 < end_e + D);
                dn  = ended && (e - 1 >= end_e + D + 1);
                ps  = dn && (end_code == 32'd0);
                return {29'd0, drn, ps, dn};
            end
        endcase
    endfunction

    // Reference model: advances at each active edge from the driven inputs.
    initial begin
        resp_t x;
        forever begin
            @(posedge clock);
            ecount = ecount + 1;
            if (reset) begin
                armed      = 1'b1;
                rst_e      = ecount;
                hb_e       = ecount;
                end_e      = -1;
                end_code   = 32'd0;
                last_req_e = -10;
                sb_q.delete();
            end else if (armed) begin
                if (wb_cyc_i && wb_stb_i && (last_req_e != ecount - 1)) begin
                    last_req_e = ecount;
                    x.err = wb_we_i && (wb_sel_i != 4'hF);
                    x.dat = wb_we_i ? 32'd0 : model_read(wb_adr_i[3:2], ecount);
                    sb_q.push_back(x);
                    if (wb_we_i && !x.err && (end_e < 0)) begin
                        if (wb_adr_i[3:2] == 2'd0) begin
                            end_e    = ecount;
                            end_code = wb_dat_i;
                        end else if (wb_adr_i[3:2] == 2'd1) begin
                            hb_e = ecount;
                        end
                    end
                end
                if ((end_e < 0) && (ecount == hb_e + L)) begin
                    end_e    = ecount;
                    end_code = WD;
                end
            end
        end
    end

    // Monitor: pops the scoreboard on every response and checks end-of-run outputs.
    initial begin
        resp_t x;
        bit    dn;
        forever begin
            @(negedge clock);
            if (armed) begin
                if (wb_ack_o || wb_err_o) begin
                    chk("resp_expected", 32'(sb_q.size() != 0), 32'd1);
                    if (sb_q.size() != 0) begin
                        x = sb_q.pop_front();
                        chk("resp_ack", 32'(wb_ack_o), 32'(!x.err));
                        chk("resp_err", 32'(wb_err_o), 32'(x.err));
                        chk("resp_data", wb_dat_o, x.dat);
                        last_rdata = wb_dat_o;
                    end
                end else begin
                    chk("idle_dat_zero", wb_dat_o, 32'd0);
                end
                chk("resp_missing", 32'(sb_q.size()), 32'd0);
                sb_q.delete();
                dn = (end_e >= 0) && (ecount >= end_e + D + 1);
                chk("sim_done", 32'(sim_done), 32'(dn));
                chk("sim_pass", 32'(sim_pass), 32'(dn && (end_code == 32'd0)));
                chk("exit_code", exit_code, (end_e >= 0) ? end_code : 32'd0);
            end
        end
    end

    task automatic bus(input logic we, input logic [3:0] adr, input logic [3:0] sel, input logic [31:0] dat);
        @(negedge clock);
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = we;
        wb_adr_i = adr;  wb_sel_i = sel;  wb_dat_i = dat;
        @(negedge clock);
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic do_reset(input int n);
        @(negedge clock);
        reset = 1'b1;
        repeat (n) @(negedge clock);
        reset = 1'b0;
    endtask

    // Absolute bound on run time.
    initial begin
        #5_000_000;
        errors++;
        $display("FAIL timeout actual=running expected=finished");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1);
    end

    // Stimulus: directed scenarios followed by randomised traffic.
    initial begin
        do_reset(2);

        // Tick count after ~50 cycles, idle status, rejected partial write.
        idle(49);
        bus(1'b0, 4'h8, 4'h0, 32'd0);
        idle(1);
        chk("ticks_range", 32'((last_rdata >= 32'd50) && (last_rdata <= 32'd52)), 32'd1);
        bus(1'b0, 4'hC, 4'hF, 32'd0);
        bus(1'b1, 4'h0, 4'h3, 32'd9);
        bus(1'b0, 4'hC, 4'h0, 32'd0);
        idle(1);
        chk("status_after_err", last_rdata, 32'd0);

        // Back-to-back strobe held for four edges: two responses.
        @(negedge clock);
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0; wb_adr_i = 4'h8;
        idle(4);
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0;

        // Passing exit.
        bus(1'b1, 4'h0, 4'hF, 32'd0);
        idle(10);
        chk("t1_done", 32'(sim_done), 32'd1);
        chk("t1_pass", 32'(sim_pass), 32'd1);
        bus(1'b0, 4'hC, 4'h0, 32'd0);
        idle(1);
        chk("t1_status", last_rdata, 32'd3);

        // First exit code wins during drain.
        do_reset(1);
        bus(1'b1, 4'h0, 4'hF, 32'd7);
        bus(1'b1, 4'h0, 4'hF, 32'd0);
        idle(10);
        chk("t2_code", exit_code, 32'd7);
        chk("t2_pass", 32'(sim_pass), 32'd0);

        // Reset mid-drain, then a fresh exit completes.
        do_reset(1);
        bus(1'b1, 4'h0, 4'hF, 32'd5);
        idle(1);
        do_reset(1);
        chk("t5_code_cleared", exit_code, 32'd0);
        bus(1'b0, 4'h8, 4'h0, 32'd0);
        bus(1'b1, 4'h0, 4'hF, 32'h12);
        idle(10);
        chk("t5_code", exit_code, 32'h12);

        // Reset coinciding with a request drops the response.
        @(negedge clock);
        reset = 1'b1; wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0; wb_adr_i = 4'h0;
        @(negedge clock);
        reset = 1'b0; wb_cyc_i = 1'b0; wb_stb_i = 1'b0;

        // Watchdog fires with no heartbeat.
        do_reset(1);
        idle(120);
        chk("t3_wd_code", exit_code, WD);
        chk("t3_wd_done", 32'(sim_done), 32'd1);

        // Heartbeat every 99 cycles keeps the run alive.
        do_reset(1);
        for (int i = 0; i < 102; i++) begin
            bus(1'b1, 4'h4, 4'hF, $urandom);
            idle(97);
        end
        chk("t3_alive", 32'(sim_done), 32'd0);

        // Exit write on the exact expiry edge beats the watchdog.
        do_reset(1);
        idle(98);
        bus(1'b1, 4'h0, 4'hF, 32'h1234_5678);
        idle(10);
        chk("t6_code", exit_code, 32'h1234_5678);

        // Randomised traffic.
        for (int r = 0; r < 6; r++) begin
            do_reset(1);
            for (int t = 0; t < 25; t++) begin
                logic [3:0]  adr;
                logic [3:0]  sel;
                logic        we;
                logic [31:0] dat;
                idle($urandom_range(0, 40));
                adr = 4'($urandom_range(0, 15));
                we  = 1'($urandom_range(0, 1));
                sel = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(0, 15)) : 4'hF;
                dat = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
                bus(we, adr, sel, dat);
            end
            idle(20);
        end

        idle(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
